// File: rtl/cordic_ln_prenorm_pkg.sv
// Shared constants for the CORDIC natural-log datapath: the range-reduction
// stage, the log core and the ln(x) reconstruction adder all import these.
package cordic_ln_prenorm_pkg;

   localparam int FRAC = 16;
   localparam int KW   = 6;

   localparam logic signed [31:0] LN2_Q16  = 32'sd45426;
   localparam logic        [31:0] MANT_ONE = 32'h0001_0000;

   // Exponent range produced by a 31-bit magnitude: p in [0,30] -> k = p - FRAC.
   localparam int K_MIN = -FRAC;
   localparam int K_MAX = 30 - FRAC;

endpackage

// File: rtl/cordic_ln_prenorm_lod32.sv
// Leading-one detector over a 31-bit magnitude: pos is the index of the
// highest set bit, zero flags an all-zero input (pos is then 0).
module cordic_lod32
(
   input  logic [30:0] data,
   output logic [4:0]  pos,
   output logic        zero
);

   // Scan low to high so the highest set bit is the last one to win.
   always_comb begin
      pos  = 5'd0;
      zero = 1'b1;
      for (int i = 0; i < 31; i++) begin
         if (data[i]) begin
            pos  = 5'(i);
            zero = 1'b0;
         end
      end
   end

endmodule

// File: rtl/cordic_ln_prenorm.sv
// Range reduction ahead of the CORDIC log core: splits a positive Q16.16
// operand into m * 2^k with m in [1.0, 2.0), and precomputes k*ln2 for the
// reconstruction adder. Three register stages, no backpressure.
module cordic_ln_prenorm
#(
   parameter int FRAC = cordic_ln_prenorm_pkg::FRAC
)
(
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [31:0]                               iData,
   input  logic                                      pre_vaild,
   output logic [31:0]                               oMant,
   output logic signed [cordic_ln_prenorm_pkg::KW-1:0] oK,
   output logic [31:0]                               oOffset,
   output logic                                      oErr,
   output logic                                      post_vaild
);

   import cordic_ln_prenorm_pkg::*;

   logic [31:0]          s1_data;
   logic                 s1_err;
   logic                 s1_vld;

   logic [31:0]          s2_data;
   logic                 s2_err;
   logic signed [KW-1:0] s2_k;
   logic                 s2_vld;

   logic [4:0]           lod_pos;
   logic                 lod_zero;
   logic signed [KW-1:0] k_calc;

   logic [4:0]           sh_amt;
   logic [31:0]          mant_calc;
   logic signed [31:0]   k_ext;
   logic signed [31:0]   off_calc;

   // Stage 1: capture the operand and flag non-positive inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_data <= '0;
         s1_err  <= 1'b0;
         s1_vld  <= 1'b0;
      end else begin
         s1_vld <= pre_vaild;
         if (pre_vaild) begin
            s1_data <= iData;
            s1_err  <= iData[31] | (iData == 32'd0);
         end
      end
   end

   cordic_lod32 u_lod
   (
      .data (s1_data[30:0]),
      .pos  (lod_pos),
      .zero (lod_zero)
   );

   // Exponent relative to the binary point; pos 0..30 maps to k -16..14.
   always_comb begin
      k_calc = $signed({1'b0, lod_pos}) - KW'(FRAC);
   end

   // Stage 2: register the exponent alongside the operand. An all-zero
   // magnitude is already an error from stage 1; OR-ing keeps it robust.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_data <= '0;
         s2_err  <= 1'b0;
         s2_k    <= '0;
         s2_vld  <= 1'b0;
      end else begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_data <= s1_data;
            s2_err  <= s1_err | lod_zero;
            s2_k    <= k_calc;
         end
      end
   end

   // Barrel shift toward [1.0, 2.0) and the exact k*ln2 product.
   always_comb begin
      sh_amt    = s2_k[KW-1] ? 5'(-s2_k) : 5'(s2_k);
      mant_calc = s2_k[KW-1] ? (s2_data << sh_amt)
                             : 32'($signed(s2_data) >>> sh_amt);
      k_ext     = 32'(s2_k);
      off_calc  = k_ext * LN2_Q16;
   end

   // Stage 3: output registers; error samples emit the neutral m = 1.0, k = 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oMant      <= '0;
         oK         <= '0;
         oOffset    <= '0;
         oErr       <= 1'b0;
         post_vaild <= 1'b0;
      end else begin
         post_vaild <= s2_vld;
         if (s2_vld) begin
            if (s2_err) begin
               oMant   <= MANT_ONE;
               oK      <= '0;
               oOffset <= '0;
               oErr    <= 1'b1;
            end else begin
               oMant   <= mant_calc;
               oK      <= s2_k;
               oOffset <= off_calc;
               oErr    <= 1'b0;
            end
         end
      end
   end

endmodule
